// File: rtl/q_fixed_pkg.sv
// Shared Q2.14 fixed-point definitions: widths, constants, state encoding and a
// generic signed clamp used by every saturating stage.
package q_fixed_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 14;
    localparam int INT_W  = 2;

    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;
    localparam logic [15:0] Q_ONE = 16'h4000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    // Clamp v into the w-bit two's complement range; caller detects saturation
    // by comparing the result with v.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/axis_q_accum_if.sv
// Stream-side bundle of the accumulator: input beat channel, coefficient and
// the single-beat result channel.
interface axis_q_accum_if #(
    parameter int data_width = 16,
    parameter int cnt_width  = 16
);
    logic [data_width-1:0] tdata_in;
    logic                  tvalid_in;
    logic                  tlast_in;
    logic                  tready_out;
    logic [data_width-1:0] coef;
    logic [data_width-1:0] tdata_out;
    logic                  tvalid_out;
    logic                  tlast_out;
    logic                  tready_in;
    logic [cnt_width-1:0]  count_out;
    logic                  sat_out;

    modport slave (
        input  tdata_in, tvalid_in, tlast_in, coef, tready_in,
        output tready_out, tdata_out, tvalid_out, tlast_out, count_out, sat_out
    );

    modport master (
        output tdata_in, tvalid_in, tlast_in, coef, tready_in,
        input  tready_out, tdata_out, tvalid_out, tlast_out, count_out, sat_out
    );
endinterface

// File: rtl/q_mul_round.sv
// Signed Q2.14 x Q2.14 multiply with round-half-up back to 14 fractional bits.
// Purely combinational; the result keeps all integer bits of the product.
module q_mul_round #(
    parameter int data_width = 16,
    parameter int frac_width = 14,
    localparam int prod_width = 2 * data_width,
    localparam int term_width = prod_width - frac_width
) (
    input  logic signed [data_width-1:0] a,
    input  logic signed [data_width-1:0] b,
    output logic signed [term_width-1:0] term
);
    localparam logic signed [prod_width-1:0] HALF = prod_width'(1) <<< (frac_width - 1);

    logic signed [prod_width-1:0] prod;
    logic signed [prod_width-1:0] rounded;

    // The most negative product plus HALF still fits, so no widening is needed.
    assign prod    = a * b;
    assign rounded = prod + HALF;
    assign term    = term_width'(rounded >>> frac_width);
endmodule

// File: rtl/axis_q_accum.sv
// Packet accumulator: scales each Q2.14 beat by a per-packet coefficient, sums
// with guard bits and emits one saturated Q2.14 result beat per input packet.
module axis_q_accum
    import q_fixed_pkg::*;
#(
    parameter int data_width = 16,
    parameter int frac_width = 14,
    parameter int int_width  = 2,
    parameter int acc_width  = 24,
    parameter int cnt_width  = 16
) (
    input logic            clk,
    input logic            reset,
    axis_q_accum_if.slave  bus
);
    localparam int term_width = 2 * data_width - frac_width;

    logic [1:0]                   state_q, state_d;
    logic signed [acc_width-1:0]  acc_q, acc_d;
    logic [cnt_width-1:0]         cnt_q, cnt_d;
    logic                         sat_q, sat_d;
    logic [data_width-1:0]        coef_q, coef_d;
    logic                         tready_q, tready_d;
    logic                         tvalid_q, tvalid_d;
    logic                         tlast_q, tlast_d;
    logic [data_width-1:0]        tdata_q, tdata_d;
    logic [cnt_width-1:0]         count_q, count_d;
    logic                         sat_out_q, sat_out_d;

    logic                         accept;
    logic [data_width-1:0]        mul_coef;
    logic signed [term_width-1:0] term;
    logic signed [acc_width-1:0]  term_ext;
    logic signed [acc_width:0]    sum;
    logic signed [63:0]           sum_clamped;
    logic signed [acc_width-1:0]  acc_next;
    logic                         sat_next;
    logic                         finish;
    logic signed [63:0]           out_clamped;

    assign accept = bus.tvalid_in && tready_q;

    // The first beat must use the live coefficient; later beats the latched one.
    assign mul_coef = (state_q == ST_IDLE) ? bus.coef : coef_q;

    q_mul_round #(
        .data_width(data_width),
        .frac_width(frac_width)
    ) u_mul (
        .a    ($signed(bus.tdata_in)),
        .b    ($signed(mul_coef)),
        .term (term)
    );

    assign term_ext    = acc_width'(term);
    assign sum         = (acc_width + 1)'(acc_q) + (acc_width + 1)'(term_ext);
    assign sum_clamped = sat_clamp(64'(sum), acc_width);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coef_d      = coef_q;
        tready_d    = tready_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        count_d     = count_q;
        sat_out_d   = sat_out_q;
        acc_next    = acc_q;
        sat_next    = sat_q;
        finish      = 1'b0;
        out_clamped = '0;

        case (state_q)
            ST_IDLE: begin
                tready_d = 1'b1;
                if (accept) begin
                    coef_d   = bus.coef;
                    acc_next = term_ext;
                    sat_next = 1'b0;
                    cnt_d    = cnt_width'(1);
                    state_d  = ST_ACCUM;
                    finish   = bus.tlast_in;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_next = acc_width'(sum_clamped);
                    sat_next = sat_q | (sum_clamped != 64'(sum));
                    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    finish   = bus.tlast_in;
                end
            end
            ST_OUTPUT: begin
                if (tvalid_q && bus.tready_in) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    acc_next = '0;
                    sat_next = 1'b0;
                    cnt_d    = '0;
                    tready_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The result is registered on the very edge that accepts the tlast beat.
        out_clamped = sat_clamp(64'(acc_next), int_width + frac_width);
        if (finish) begin
            tdata_d   = data_width'(out_clamped);
            sat_out_d = sat_next | (out_clamped != 64'(acc_next));
            count_d   = cnt_d;
            tvalid_d  = 1'b1;
            tlast_d   = 1'b1;
            tready_d  = 1'b0;
            state_d   = ST_OUTPUT;
        end

        acc_d = acc_next;
        sat_d = sat_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            coef_q    <= '0;
            tready_q  <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            count_q   <= '0;
            sat_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            coef_q    <= coef_d;
            tready_q  <= tready_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            count_q   <= count_d;
            sat_out_q <= sat_out_d;
        end
    end

    assign bus.tready_out = tready_q;
    assign bus.tvalid_out = tvalid_q;
    assign bus.tlast_out  = tlast_q;
    assign bus.tdata_out  = tdata_q;
    assign bus.count_out  = count_q;
    assign bus.sat_out    = sat_out_q;
endmodule

// File: tb/tb_axis_q_accum.sv
// Self-checking bench for axis_q_accum: directed cases plus random packets,
// compared against an integer-arithmetic model of one packet's result.
module tb_axis_q_accum;
    import q_fixed_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    axis_q_accum_if #(.data_width(16), .cnt_width(16)) bus();

    axis_q_accum #(
        .data_width(16),
        .frac_width(14),
        .int_width(2),
        .acc_width(24),
        .cnt_width(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] pkt_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-packet reference: sum of rounded products, 24-bit clamp, then Q2.14 clamp.
    task automatic modelPacket(input logic [15:0] c, output logic [15:0] res,
                               output logic s, output int n);
        longint acc;
        longint p;
        longint term;
        acc = 0;
        s   = 1'b0;
        n   = pkt_q.size();
        foreach (pkt_q[i]) begin
            p    = longint'($signed(pkt_q[i])) * longint'($signed(c));
            term = (p + 64'sd8192) >>> 14;
            acc  = acc + term;
            if (acc > 64'sd8388607) begin
                acc = 64'sd8388607;
                s   = 1'b1;
            end else if (acc < -64'sd8388608) begin
                acc = -64'sd8388608;
                s   = 1'b1;
            end
        end
        if (acc > 64'sd32767) begin
            res = Q_MAX;
            s   = 1'b1;
        end else if (acc < -64'sd32768) begin
            res = Q_MIN;
            s   = 1'b1;
        end else begin
            res = 16'(acc);
        end
    endtask

    // Send the first n_send beats of pkt_q; coef is scrambled after the first beat.
    task automatic applyStimulus(input logic [15:0] c, input int n_send, input bit gaps);
        int  i;
        int  guard;
        bit  will_accept;
        i     = 0;
        guard = 0;
        while (i < n_send) begin
            @(negedge clk);
            bus.tvalid_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.tdata_in  = pkt_q[i];
            bus.tlast_in  = (i == pkt_q.size() - 1);
            bus.coef      = (i == 0) ? c : 16'($urandom);
            will_accept   = bus.tvalid_in && bus.tready_out;
            @(posedge clk);
            if (will_accept) i++;
            guard++;
            if (guard > 200) begin
                checkOutput("beat_timeout", 32'(i), 32'(n_send));
                return;
            end
        end
    endtask

    task automatic checkResult(input logic [15:0] c, input int stall);
        logic [15:0] er;
        logic        es;
        int          en;
        modelPacket(c, er, es, en);
        @(negedge clk);
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        checkOutput("tvalid_latency", 32'(bus.tvalid_out), 32'd1);
        checkOutput("tlast_out", 32'(bus.tlast_out), 32'd1);
        checkOutput("tdata_out", 32'(bus.tdata_out), 32'(er));
        checkOutput("count_out", 32'(bus.count_out), 32'(en));
        checkOutput("sat_out", 32'(bus.sat_out), 32'(es));
        checkOutput("tready_in_output", 32'(bus.tready_out), 32'd0);
        repeat (stall) begin
            @(negedge clk);
            checkOutput("hold_tdata", 32'(bus.tdata_out), 32'(er));
            checkOutput("hold_count", 32'(bus.count_out), 32'(en));
            checkOutput("hold_tvalid", 32'(bus.tvalid_out), 32'd1);
            checkOutput("hold_tready", 32'(bus.tready_out), 32'd0);
        end
        bus.tready_in = 1'b1;
        @(negedge clk);
        bus.tready_in = 1'b0;
        checkOutput("tvalid_after_hs", 32'(bus.tvalid_out), 32'd0);
        checkOutput("tready_after_hs", 32'(bus.tready_out), 32'd1);
    endtask

    task automatic runPacket(input logic [15:0] c, input int stall);
        applyStimulus(c, pkt_q.size(), 1'b0);
        checkResult(c, stall);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tready"}, 32'(bus.tready_out), 32'd0);
        checkOutput({tag, "_tvalid"}, 32'(bus.tvalid_out), 32'd0);
        checkOutput({tag, "_tlast"}, 32'(bus.tlast_out), 32'd0);
        checkOutput({tag, "_tdata"}, 32'(bus.tdata_out), 32'd0);
        checkOutput({tag, "_count"}, 32'(bus.count_out), 32'd0);
        checkOutput({tag, "_sat"}, 32'(bus.sat_out), 32'd0);
    endtask

    initial begin
        logic [15:0] c;
        int          n;
        bus.tdata_in  = '0;
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        bus.coef      = '0;
        bus.tready_in = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);
        checkOutput("tready_rise", 32'(bus.tready_out), 32'd1);

        pkt_q = '{16'h1000, 16'h1000, 16'h1000};
        runPacket(16'h4000, 0);
        pkt_q = '{16'h2000};
        runPacket(16'hC000, 0);
        pkt_q = '{16'h7000, 16'h7000};
        runPacket(16'h4000, 0);
        pkt_q = '{16'h9000, 16'h9000};
        runPacket(16'h4000, 0);
        pkt_q = '{16'h2000};
        runPacket(16'h0001, 0);
        pkt_q = '{16'h1FFF};
        runPacket(16'h0001, 0);
        pkt_q = '{16'h0400, 16'hFC00, 16'h0C00};
        runPacket(16'h4000, 5);
        pkt_q = '{16'h0100, 16'h0100};
        runPacket(16'h4000, 0);

        // Abort a packet after two of four beats, then confirm a clean restart.
        pkt_q = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        applyStimulus(16'h4000, 2, 1'b0);
        @(negedge clk);
        bus.tvalid_in = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b0;
        @(negedge clk);
        checkOutput("tready_after_reset", 32'(bus.tready_out), 32'd1);
        pkt_q = '{16'h0800, 16'h0800};
        runPacket(16'h4000, 0);

        repeat (25) begin
            n = $urandom_range(1, 6);
            pkt_q.delete();
            for (int k = 0; k < n; k++) begin
                pkt_q.push_back(($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom));
            end
            c = 16'($urandom);
            applyStimulus(c, n, 1'b1);
            checkResult(c, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
